adder_accum_nch: RTL and testbench

Multi-channel accumulating adder. It is the parametrised successor to the fixed 2-bit adder cell.
- Each of NUM_CH channels holds a running unsigned sum of operands presented on a shared valid/ready input stream.
- After each accepted beat, the updated sum and a sticky overflow flag are emitted on a registered valid/ready output stream.
- Sits between operand sources and a result collector inside datapath test structures; replaces per-channel adder instances with one shared block.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_accum_nch_if.sv | 29 ++
 rtl/adder_sat_cell.sv | 27 ++
 rtl/adder_accum_nch.sv | 103 ++++++++++
 tb/tb_adder_accum_nch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and width helpers for the multi-channel accumulating adder.
package adder_pkg;

  localparam int SAT_WRAP    = 0;
  localparam int SAT_CLAMP   = 1;
  localparam int SUM_RST_VAL = 0;

  function automatic int calc_sum_w(input int width, input int guard);
    return width + guard;
  endfunction

  // A single-channel build still needs a 1-bit channel field.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/adder_accum_nch_if.sv
// Operand input stream and result output stream of the accumulating adder.
interface adder_accum_nch_if #(
  parameter int WIDTH = 2,
  parameter int CH_W  = 2,
  parameter int SUM_W = 4
);
  // Both streams: a beat transfers on a rising edge where valid && ready;
  // the producer holds valid and payload stable until it transfers.
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch;
  logic [WIDTH-1:0] in_data;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [SUM_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_ch, in_data, in_clr, out_ready,
    input  in_ready, out_valid, out_ch, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_ch, in_data, in_clr, out_ready,
    output in_ready, out_valid, out_ch, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_sat_cell.sv
// Combinational unsigned add of an operand onto a sum, with optional clamping.
module adder_sat_cell
  import adder_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int SUM_W    = 4,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic [SUM_W-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SUM_W-1:0] sum,
  output logic             of
);

  logic [SUM_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {{(SUM_W + 1 - WIDTH){1'b0}}, b};
    of  = raw[SUM_W];
    if ((SATURATE == SAT_CLAMP) && of) begin
      sum = '1;
    end else begin
      sum = raw[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/adder_accum_nch.sv
// Per-channel running sums with sticky overflow, fed and drained through
// valid/ready streams with a single registered result stage.
module adder_accum_nch
  import adder_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int NUM_CH   = 4,
  parameter int GUARD    = 2,
  parameter int SATURATE = SAT_WRAP,
  parameter int CHECK    = 1
) (
  input logic              clk,
  input logic              rst_n,
  adder_accum_nch_if.slave bus
);

  localparam int SUM_W = calc_sum_w(WIDTH, GUARD);
  localparam int CH_W  = calc_ch_w(NUM_CH);

  logic [SUM_W-1:0] acc [NUM_CH];
  logic [NUM_CH-1:0] ovf_stk;

  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [SUM_W-1:0] out_sum_q;
  logic             out_ovf_q;

  logic             accept;
  logic             upd;
  logic             ch_ok;
  logic [SUM_W-1:0] cur_acc;
  logic             cur_stk;
  logic [SUM_W-1:0] cell_a;
  logic [SUM_W-1:0] new_sum;
  logic             new_of;
  logic             new_stk;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign upd    = accept && ch_ok;

  // Channel select by match so an out-of-range in_ch never indexes past acc.
  always_comb begin
    cur_acc = '0;
    cur_stk = 1'b0;
    ch_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.in_ch == CH_W'(i)) begin
        cur_acc = acc[i];
        cur_stk = ovf_stk[i];
        ch_ok   = 1'b1;
      end
    end
  end

  assign cell_a  = bus.in_clr ? '0 : cur_acc;
  assign new_stk = (CHECK != 0) && ((!bus.in_clr && cur_stk) || new_of);

  adder_sat_cell #(
    .WIDTH    (WIDTH),
    .SUM_W    (SUM_W),
    .SATURATE (SATURATE)
  ) u_cell (
    .a   (cell_a),
    .b   (bus.in_data),
    .sum (new_sum),
    .of  (new_of)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= SUM_W'(SUM_RST_VAL);
      end
      ovf_stk     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= SUM_W'(SUM_RST_VAL);
      out_ovf_q   <= 1'b0;
    end else begin
      if (upd) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.in_ch == CH_W'(i)) begin
            acc[i]     <= new_sum;
            ovf_stk[i] <= new_stk;
          end
        end
        out_valid_q <= 1'b1;
        out_ch_q    <= bus.in_ch;
        out_sum_q   <= new_sum;
        out_ovf_q   <= new_stk;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_accum_nch.sv
// Directed bench: wrap, clamp and unchecked variants share one stimulus stream.
module tb_adder_accum_nch;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [1:0] in_data;
  logic       in_clr;
  logic       out_ready;

  int errors;
  int checks;

  adder_accum_nch_if #(.WIDTH(2), .CH_W(2), .SUM_W(4)) bus_d ();
  adder_accum_nch_if #(.WIDTH(2), .CH_W(2), .SUM_W(4)) bus_s ();
  adder_accum_nch_if #(.WIDTH(2), .CH_W(2), .SUM_W(4)) bus_c ();

  assign bus_d.in_valid = in_valid;
  assign bus_d.in_ch = in_ch;
  assign bus_d.in_data = in_data;
  assign bus_d.in_clr = in_clr;
  assign bus_d.out_ready = out_ready;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_ch = in_ch;
  assign bus_s.in_data = in_data;
  assign bus_s.in_clr = in_clr;
  assign bus_s.out_ready = out_ready;
  assign bus_c.in_valid = in_valid;
  assign bus_c.in_ch = in_ch;
  assign bus_c.in_data = in_data;
  assign bus_c.in_clr = in_clr;
  assign bus_c.out_ready = out_ready;

  adder_accum_nch #(.WIDTH(2), .NUM_CH(4), .GUARD(2), .SATURATE(0), .CHECK(1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  adder_accum_nch #(.WIDTH(2), .NUM_CH(4), .GUARD(2), .SATURATE(1), .CHECK(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  adder_accum_nch #(.WIDTH(2), .NUM_CH(4), .GUARD(2), .SATURATE(0), .CHECK(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [1:0] ch, input logic [1:0] data, input logic clr);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = data;
    in_clr   = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus_d.out_valid !== 1'b0 || bus_d.out_sum !== 4'd0 || bus_d.out_ovf !== 1'b0 ||
        bus_d.out_ch !== 2'd0 || bus_d.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b ch=%0d sum=%0d ovf=%b rdy=%b want 0 0 0 0 1",
               bus_d.out_valid, bus_d.out_ch, bus_d.out_sum, bus_d.out_ovf, bus_d.in_ready);
    end
    out_ready = 1'b0;
    beat(2'd1, 2'd3, 1'b0);
    checks++;
    if (bus_d.out_valid !== 1'b1 || bus_d.out_sum !== 4'd3 || bus_d.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got v=%b sum=%0d rdy=%b want 1 3 0",
               bus_d.out_valid, bus_d.out_sum, bus_d.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_drop: got v=%b want 0", bus_d.out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b0 || bus_d.out_sum !== 4'd0 || bus_d.out_ovf !== 1'b0 ||
        bus_d.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_stream: got v=%b sum=%0d ovf=%b rdy=%b want 0 0 0 1",
               bus_d.out_valid, bus_d.out_sum, bus_d.out_ovf, bus_d.in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_accumulate();
    logic [3:0] exp_sum [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
    logic       exp_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      beat(2'd1, 2'd3, 1'b0);
      checks++;
      if (bus_d.out_valid !== 1'b1 || bus_d.out_ch !== 2'd1 ||
          bus_d.out_sum !== exp_sum[i] || bus_d.out_ovf !== exp_ovf[i]) begin
        errors++;
        $display("FAIL accum_beat%0d: got v=%b ch=%0d sum=%0d ovf=%b want 1 1 %0d %b", i,
                 bus_d.out_valid, bus_d.out_ch, bus_d.out_sum, bus_d.out_ovf, exp_sum[i], exp_ovf[i]);
      end
      checks++;
      if (bus_c.out_sum !== exp_sum[i] || bus_c.out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL nocheck_beat%0d: got sum=%0d ovf=%b want %0d 0", i,
                 bus_c.out_sum, bus_c.out_ovf, exp_sum[i]);
      end
    end
    beat(2'd0, 2'd0, 1'b0);
    checks++;
    if (bus_d.out_ch !== 2'd0 || bus_d.out_sum !== 4'd0 || bus_d.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL accum_ch0_idle: got ch=%0d sum=%0d ovf=%b want 0 0 0",
               bus_d.out_ch, bus_d.out_sum, bus_d.out_ovf);
    end
    beat(2'd1, 2'd0, 1'b0);
    checks++;
    if (bus_d.out_sum !== 4'd2 || bus_d.out_ovf !== 1'b1 || bus_s.out_sum !== 4'd15 ||
        bus_c.out_sum !== 4'd2 || bus_c.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL accum_add_zero: got d=%0d/%b s=%0d c=%0d/%b want 2/1 15 2/0",
               bus_d.out_sum, bus_d.out_ovf, bus_s.out_sum, bus_c.out_sum, bus_c.out_ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL accum_drain: got v=%b want 0", bus_d.out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_sum [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
    logic       exp_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      beat(2'd2, 2'd3, 1'b0);
      checks++;
      if (bus_s.out_ch !== 2'd2 || bus_s.out_sum !== exp_sum[i] || bus_s.out_ovf !== exp_ovf[i]) begin
        errors++;
        $display("FAIL sat_beat%0d: got ch=%0d sum=%0d ovf=%b want 2 %0d %b", i,
                 bus_s.out_ch, bus_s.out_sum, bus_s.out_ovf, exp_sum[i], exp_ovf[i]);
      end
    end
    beat(2'd2, 2'd1, 1'b1);
    checks++;
    if (bus_s.out_sum !== 4'd1 || bus_s.out_ovf !== 1'b0 ||
        bus_d.out_sum !== 4'd1 || bus_d.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got s=%0d/%b d=%0d/%b want 1/0 1/0",
               bus_s.out_sum, bus_s.out_ovf, bus_d.out_sum, bus_d.out_ovf);
    end
  endtask

  task automatic test_interleave();
    logic [1:0] chs   [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
    logic [1:0] dats  [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [3:0] sums  [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
    for (int i = 0; i < 4; i++) begin
      beat(chs[i], dats[i], 1'b0);
      checks++;
      if (bus_d.out_valid !== 1'b1 || bus_d.out_ch !== chs[i] || bus_d.out_sum !== sums[i]) begin
        errors++;
        $display("FAIL interleave%0d: got v=%b ch=%0d sum=%0d want 1 %0d %0d", i,
                 bus_d.out_valid, bus_d.out_ch, bus_d.out_sum, chs[i], sums[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    beat(2'd3, 2'd1, 1'b1);
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 2'd2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_d.out_valid !== 1'b1 || bus_d.out_ch !== 2'd3 || bus_d.out_sum !== 4'd1 ||
          bus_d.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: got v=%b ch=%0d sum=%0d rdy=%b want 1 3 1 0", i,
                 bus_d.out_valid, bus_d.out_ch, bus_d.out_sum, bus_d.in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (bus_d.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1", bus_d.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b1 || bus_d.out_sum !== 4'd3) begin
      errors++;
      $display("FAIL release_first: got v=%b sum=%0d want 1 3", bus_d.out_valid, bus_d.out_sum);
    end
    in_data = 2'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (bus_d.out_valid !== 1'b1 || bus_d.out_sum !== 4'd6) begin
      errors++;
      $display("FAIL release_second: got v=%b sum=%0d want 1 6", bus_d.out_valid, bus_d.out_sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_drain: got v=%b want 0", bus_d.out_valid);
    end
  endtask

  task automatic test_clear_zero();
    beat(2'd1, 2'd0, 1'b1);
    checks++;
    if (bus_d.out_sum !== 4'd0 || bus_d.out_ovf !== 1'b0 ||
        bus_s.out_sum !== 4'd0 || bus_s.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_zero: got d=%0d/%b s=%0d/%b want 0/0 0/0",
               bus_d.out_sum, bus_d.out_ovf, bus_s.out_sum, bus_s.out_ovf);
    end
    beat(2'd1, 2'd2, 1'b0);
    checks++;
    if (bus_d.out_sum !== 4'd2 || bus_d.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_then_add: got %0d/%b want 2/0", bus_d.out_sum, bus_d.out_ovf);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = 2'd0;
    in_data   = 2'd0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_saturate();
    test_interleave();
    test_back_to_back();
    test_clear_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
